// File: rtl/regfile_rdpipe.sv
// -----------------------------------------------------------------------------
// regfile_rdpipe
//
// Parametrised register file: one write port and NUM_RD independent read
// ports. Each read port is registered, so data appears exactly one cycle
// after the request, together with a one-cycle valid strobe. A read that
// addresses the register being written on the same edge returns the new
// write data (write-first bypass). Reads at addresses >= DEPTH return zero
// and raise the port's error flag. Writes at addresses >= DEPTH are dropped.
//
// Optional build macro:
//   REGFILE_ZERO_REG_EN  - register 0 is hard-wired to zero. Writes to it are
//                          dropped, so reads of address 0 (bypassed or not)
//                          return zero with no error.
//
// Parameters:
//   WIDTH   data width in bits (>=1)
//   DEPTH   number of registers (>=2, any value)
//   NUM_RD  number of read ports (>=1)
//   AW      address width, $clog2(DEPTH) (derived, not overridable)
//
// Ports:
//   CLK_i       clock, rising-edge active
//   RST_Ni      asynchronous active-low reset (clears storage and outputs)
//   WR_EN_i     write enable
//   WR_ADDR_i   write address
//   WR_DATA_i   write data
//   RD_EN_i     per-port read request
//   RD_ADDR_i   flattened read addresses, port p at [p*AW +: AW]
//   RD_DATA_o   flattened registered read data, port p at [p*WIDTH +: WIDTH]
//   RD_VALID_o  per-port data-valid strobe (one cycle after the request)
//   RD_ERR_o    per-port out-of-range flag, meaningful when RD_VALID_o is high
// -----------------------------------------------------------------------------
module regfile_rdpipe #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    CLK_i,
    input  logic                    RST_Ni,
    input  logic                    WR_EN_i,
    input  logic [AW-1:0]           WR_ADDR_i,
    input  logic [WIDTH-1:0]        WR_DATA_i,
    input  logic [NUM_RD-1:0]       RD_EN_i,
    input  logic [NUM_RD*AW-1:0]    RD_ADDR_i,
    output logic [NUM_RD*WIDTH-1:0] RD_DATA_o,
    output logic [NUM_RD-1:0]       RD_VALID_o,
    output logic [NUM_RD-1:0]       RD_ERR_o
);

    // DEPTH as an AW+1 bit constant so the range compare is width-exact even
    // when DEPTH is a power of two (DEPTH itself needs AW+1 bits then).
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // Storage and registered read outputs
    logic [DEPTH-1:0][WIDTH-1:0]  r_mem;
    logic [NUM_RD-1:0][WIDTH-1:0] r_rd_data;
    logic [NUM_RD-1:0]            r_rd_valid;
    logic [NUM_RD-1:0]            r_rd_err;

    // Combinational decode and next-state values
    logic                         w_wr_inr;
    logic                         w_wr_hit;
    logic [NUM_RD-1:0]            w_rd_inr;
    logic [NUM_RD-1:0]            w_rd_byp;
    logic [NUM_RD-1:0][WIDTH-1:0] w_rd_mem;
    logic [NUM_RD-1:0][WIDTH-1:0] w_rd_data_nxt;
    logic [NUM_RD-1:0]            w_rd_valid_nxt;
    logic [NUM_RD-1:0]            w_rd_err_nxt;

    assign w_wr_inr = ({1'b0, WR_ADDR_i} < DEPTH_W);

    // w_wr_hit marks a write that really updates a register; the bypass path
    // keys off the same signal so a dropped write can never be bypassed.
`ifdef REGFILE_ZERO_REG_EN
    assign w_wr_hit = WR_EN_i && w_wr_inr && (WR_ADDR_i != {AW{1'b0}});
`else
    assign w_wr_hit = WR_EN_i && w_wr_inr;
`endif

    // Per-port address decode: range check, bypass match and storage mux
    always_comb begin
        w_rd_inr = '0;
        w_rd_byp = '0;
        w_rd_mem = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_rd_inr[p] = ({1'b0, RD_ADDR_i[p*AW +: AW]} < DEPTH_W);
            w_rd_byp[p] = w_wr_hit && (RD_ADDR_i[p*AW +: AW] == WR_ADDR_i);
            // AND-OR mux over real entries only; an out-of-range address
            // selects nothing and yields zero.
            for (int i = 0; i < DEPTH; i++) begin
                w_rd_mem[p] = w_rd_mem[p]
                            | ({WIDTH{RD_ADDR_i[p*AW +: AW] == AW'(i)}} & r_mem[i]);
            end
        end
    end

    // Per-port next read result; idle ports hold data and error flag
    always_comb begin
        w_rd_data_nxt  = r_rd_data;
        w_rd_err_nxt   = r_rd_err;
        w_rd_valid_nxt = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (RD_EN_i[p]) begin
                w_rd_valid_nxt[p] = 1'b1;
                if (!w_rd_inr[p]) begin
                    w_rd_data_nxt[p] = '0;
                    w_rd_err_nxt[p]  = 1'b1;
                end else if (w_rd_byp[p]) begin
                    w_rd_data_nxt[p] = WR_DATA_i;
                    w_rd_err_nxt[p]  = 1'b0;
                end else begin
                    w_rd_data_nxt[p] = w_rd_mem[p];
                    w_rd_err_nxt[p]  = 1'b0;
                end
            end else begin
                w_rd_valid_nxt[p] = 1'b0;
            end
        end
    end

    // Register storage: async clear, single-port write on a qualified hit
    always_ff @(posedge CLK_i or negedge RST_Ni) begin
        if (!RST_Ni) begin
            r_mem <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_hit && (WR_ADDR_i == AW'(i))) begin
                    r_mem[i] <= WR_DATA_i;
                end
            end
        end
    end

    // Read output pipeline stage; reset drops any in-flight read
    always_ff @(posedge CLK_i or negedge RST_Ni) begin
        if (!RST_Ni) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
            r_rd_err   <= '0;
        end else begin
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_err   <= w_rd_err_nxt;
        end
    end

    assign RD_DATA_o  = r_rd_data;
    assign RD_VALID_o = r_rd_valid;
    assign RD_ERR_o   = r_rd_err;

endmodule

// File: tb/tb_regfile_rdpipe.sv
// -----------------------------------------------------------------------------
// tb_regfile_rdpipe
//
// Self-checking bench for regfile_rdpipe with WIDTH=8, DEPTH=6, NUM_RD=2, so
// addresses 6 and 7 are out of range. Directed vectors carry their expected
// outputs; a random phase derives expectations from a small behavioural model.
// Expected records go into a scoreboard queue as stimulus is driven and are
// popped and compared one cycle later when the DUT output is due.
// -----------------------------------------------------------------------------
module tb_regfile_rdpipe;

    typedef struct {
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [7:0] wr_data;
        logic [1:0] rd_en;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] e;
    } vec_t;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif
    localparam logic [7:0] ZV = ZR ? 8'h00 : 8'h77;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  rd_en;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb_q[$];
    vec_t last;
    vec_t tbl[17];

    regfile_rdpipe #(.WIDTH(8), .DEPTH(6), .NUM_RD(2)) dut (
        .CLK_i      (clk),
        .RST_Ni     (rst_n),
        .WR_EN_i    (wr_en),
        .WR_ADDR_i  (wr_addr),
        .WR_DATA_i  (wr_data),
        .RD_EN_i    (rd_en),
        .RD_ADDR_i  (rd_addr),
        .RD_DATA_o  (rd_data),
        .RD_VALID_o (rd_valid),
        .RD_ERR_o   (rd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                input logic [1:0] re, input logic [2:0] a0, input logic [2:0] a1,
                                input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [1:0] e);
        vec_t r;
        r.wr_en = we; r.wr_addr = wa; r.wr_data = wd; r.rd_en = re;
        r.a0 = a0; r.a1 = a1; r.v = v; r.d0 = d0; r.d1 = d1; r.e = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one vector (called right after a falling edge), clock it, compare.
    task automatic apply(input vec_t v, input string tag);
        vec_t x;
        wr_en   = v.wr_en;
        wr_addr = v.wr_addr;
        wr_data = v.wr_data;
        rd_en   = v.rd_en;
        rd_addr = {v.a1, v.a0};
        sb_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = sb_q.pop_front();
            chk({tag, ".valid"}, 32'(rd_valid), 32'(x.v));
            chk({tag, ".d0"}, 32'(rd_data[7:0]), 32'(x.d0));
            chk({tag, ".d1"}, 32'(rd_data[15:8]), 32'(x.d1));
            chk({tag, ".err"}, 32'(rd_err), 32'(x.e));
            last = x;
        end
    endtask

    logic [7:0] m_mem [0:5];
    logic [7:0] md [2];
    logic       me [2];
    logic [2:0] ma [2];

    initial begin
        //            we    wa    wd     re     a0    a1    v      d0     d1     e
        tbl[0]  = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd0, 3'd1, 2'b11, 8'h00, 8'h00, 2'b00);
        tbl[1]  = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd2, 3'd3, 2'b11, 8'h00, 8'h00, 2'b00);
        tbl[2]  = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd4, 3'd5, 2'b11, 8'h00, 8'h00, 2'b00);
        tbl[3]  = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd6, 3'd7, 2'b11, 8'h00, 8'h00, 2'b11);
        tbl[4]  = mk(1'b1, 3'd3, 8'hA5, 2'b00, 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 2'b11);
        tbl[5]  = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd3, 3'd3, 2'b11, 8'hA5, 8'hA5, 2'b00);
        tbl[6]  = mk(1'b1, 3'd5, 8'h11, 2'b00, 3'd0, 3'd0, 2'b00, 8'hA5, 8'hA5, 2'b00);
        tbl[7]  = mk(1'b1, 3'd5, 8'h3C, 2'b10, 3'd0, 3'd5, 2'b10, 8'hA5, 8'h3C, 2'b00);
        tbl[8]  = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd5, 3'd5, 2'b11, 8'h3C, 8'h3C, 2'b00);
        tbl[9]  = mk(1'b1, 3'd7, 8'hFF, 2'b11, 3'd7, 3'd2, 2'b11, 8'h00, 8'h00, 2'b01);
        tbl[10] = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd3, 3'd5, 2'b11, 8'hA5, 8'h3C, 2'b00);
        tbl[11] = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd0, 3'd1, 2'b11, 8'h00, 8'h00, 2'b00);
        tbl[12] = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd2, 3'd4, 2'b11, 8'h00, 8'h00, 2'b00);
        tbl[13] = mk(1'b1, 3'd2, 8'h5A, 2'b11, 3'd2, 3'd2, 2'b11, 8'h5A, 8'h5A, 2'b00);
        tbl[14] = mk(1'b1, 3'd6, 8'hEE, 2'b01, 3'd6, 3'd0, 2'b01, 8'h00, 8'h5A, 2'b01);
        tbl[15] = mk(1'b1, 3'd4, 8'h99, 2'b10, 3'd0, 3'd3, 2'b10, 8'h00, 8'hA5, 2'b01);
        tbl[16] = mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd4, 3'd2, 2'b11, 8'h99, 8'h5A, 2'b00);

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
        rd_en = 2'b00; rd_addr = 6'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset.valid", 32'(rd_valid), 32'd0);
        chk("reset.data", 32'(rd_data), 32'd0);
        chk("reset.err", 32'(rd_err), 32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int k = 0; k < 17; k++) begin
            apply(tbl[k], $sformatf("vec%0d", k));
        end

        // In-flight read killed by asynchronous reset
        wr_en = 1'b0; rd_en = 2'b11; rd_addr = {3'd5, 3'd3};
        @(posedge clk); #1;
        chk("inflight.valid", 32'(rd_valid), 32'd3);
        chk("inflight.d0", 32'(rd_data[7:0]), 32'hA5);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async.valid", 32'(rd_valid), 32'd0);
        chk("rst_async.data", 32'(rd_data), 32'd0);
        chk("rst_async.err", 32'(rd_err), 32'd0);
        @(negedge clk);
        rd_en = 2'b00; rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release.valid", 32'(rd_valid), 32'd0);

        // All registers cleared by the reset
        apply(mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd6, 3'd7, 2'b11, 8'h00, 8'h00, 2'b11), "clr67");
        apply(mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd4, 3'd5, 2'b11, 8'h00, 8'h00, 2'b00), "clr45");
        apply(mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd2, 3'd3, 2'b11, 8'h00, 8'h00, 2'b00), "clr23");
        apply(mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd0, 3'd1, 2'b11, 8'h00, 8'h00, 2'b00), "clr01");

        // Register 0 write with same-edge read, then read back from storage
        apply(mk(1'b1, 3'd0, 8'h77, 2'b01, 3'd0, 3'd0, 2'b01, ZV, 8'h00, 2'b00), "zero_byp");
        apply(mk(1'b0, 3'd0, 8'h00, 2'b11, 3'd0, 3'd0, 2'b11, ZV, ZV, 2'b00), "zero_rd");

        // Random phase against a behavioural model
        for (int i = 0; i < 6; i++) m_mem[i] = 8'h00;
        m_mem[0] = ZV;
        md[0] = last.d0; md[1] = last.d1;
        me[0] = last.e[0]; me[1] = last.e[1];
        for (int k = 0; k < 300; k++) begin
            vec_t v;
            v.wr_en   = 1'($urandom_range(0, 1));
            v.wr_addr = 3'($urandom_range(0, 7));
            v.wr_data = 8'($urandom);
            v.rd_en   = 2'($urandom_range(0, 3));
            v.a0      = 3'($urandom_range(0, 7));
            v.a1      = 3'($urandom_range(0, 7));
            ma[0] = v.a0; ma[1] = v.a1;
            for (int p = 0; p < 2; p++) begin
                if (v.rd_en[p]) begin
                    if (ma[p] >= 3'd6) begin
                        md[p] = 8'h00; me[p] = 1'b1;
                    end else if (ZR && ma[p] == 3'd0) begin
                        md[p] = 8'h00; me[p] = 1'b0;
                    end else if (v.wr_en && v.wr_addr == ma[p]) begin
                        md[p] = v.wr_data; me[p] = 1'b0;
                    end else begin
                        md[p] = m_mem[ma[p]]; me[p] = 1'b0;
                    end
                end
            end
            v.v = v.rd_en; v.d0 = md[0]; v.d1 = md[1]; v.e = {me[1], me[0]};
            if (v.wr_en && v.wr_addr < 3'd6 && !(ZR && v.wr_addr == 3'd0)) begin
                m_mem[v.wr_addr] = v.wr_data;
            end
            apply(v, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_rdpipe.md
Name: regfile_rdpipe

Overview:
- Parametrised register file with N independent registered read ports and one write port.
- Next-generation replacement for the fixed 8-entry, 8-bit combinational read mux in the 8-bit register file.
- Generalised in data width, depth and read-port count.
- Adds storage, write-first bypass, a one-cycle registered read with valid strobe, and out-of-range detection.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 8, number of registers (>=2; need not be a power of two).
- NUM_RD, 2, number of read ports (>=1).
- AW, $clog2(DEPTH), address width (localparam, not overridable).

Ports:
- Interface rule: one clock; reset is asynchronous and active-low.
- CLK_i  input  1  clock; all state updates on rising edge.
- RST_Ni  input  1  asynchronous active-low reset.
- WR_EN_i  input  1  write enable.
- WR_ADDR_i  input  AW  write address.
- WR_DATA_i  input  WIDTH  write data.
- RD_EN_i  input  NUM_RD  per-port read request.
- RD_ADDR_i  input  NUM_RD*AW  flattened read addresses; port p occupies [p*AW +: AW].
- RD_DATA_o  output  NUM_RD*WIDTH  flattened registered read data; port p occupies [p*WIDTH +: WIDTH].
- RD_VALID_o  output  NUM_RD  per-port data-valid strobe.
- RD_ERR_o  output  NUM_RD  per-port out-of-range flag, qualified by RD_VALID_o.

Behaviour:
- Reset (RST_Ni low, asynchronous, no clock needed):
  - All DEPTH registers clear to 0.
  - RD_DATA_o, RD_VALID_o and RD_ERR_o clear to 0.
  - State holds at 0 while RST_Ni is low. Release is synchronised externally.
- Write:
  - At a rising edge with WR_EN_i=1 and WR_ADDR_i<DEPTH, the register at WR_ADDR_i loads WR_DATA_i.
  - WR_ADDR_i>=DEPTH is silently ignored; no register changes.
- Read, per port p, independently:
  - RD_EN_i[p] and its address are sampled at a rising edge. Latency is exactly 1 cycle.
  - In the following cycle RD_VALID_o[p]=1 and the port's RD_DATA_o slice holds the data.
  - RD_EN_i[p]=0: RD_VALID_o[p]=0 next cycle. RD_DATA_o slice and RD_ERR_o[p] hold their previous values.
- Write-first bypass:
  - Applies when, on the same edge, RD_EN_i[p]=1, WR_EN_i=1 and the two addresses are equal and <DEPTH.
  - The port returns WR_DATA_i, not the old register contents.
  - Any number of ports may bypass on the same edge.
- Out of range:
  - RD_EN_i[p]=1 with address>=DEPTH: next cycle RD_VALID_o[p]=1, data slice=0, RD_ERR_o[p]=1.
  - In-range reads drive RD_ERR_o[p]=0.
- Simultaneous reads: all ports may address the same or different registers in the same cycle, with no arbitration and no stalls.
- Reset mid-operation: an in-flight read is discarded. RD_VALID_o drops to 0 immediately on RST_Ni low, with no completion after release.
- No back-pressure: consumers must accept data in the valid cycle.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hard-wired to zero. Writes to address 0 are ignored.
  - Reads of address 0 return 0, including under bypass with a same-edge write of nonzero data.
  - RD_ERR_o=0 for these reads.
- Undefined: register 0 is an ordinary storage register.

Test Plan:
- Reset, then read all 8 addresses on port 0 -> each returns 0x00 with RD_VALID_o[0]=1 one cycle after request.
- Write 0xA5 to addr 3, next cycle read addr 3 on port 0 and port 1 -> both slices =0xA5, RD_VALID_o=2'b11, RD_ERR_o=2'b00 one cycle later.
- Bypass: with addr 5 holding 0x11, on the same edge write 0x3C to addr 5 and read addr 5 on port 1 -> port 1 returns 0x3C; a read of addr 5 on the next edge also returns 0x3C.
- With DEPTH=6, read addr 7 on port 0 -> data 0x00, RD_VALID_o[0]=1, RD_ERR_o[0]=1; a write of 0xFF to addr 7 leaves all six registers unchanged.
- Issue reads on both ports, then pull RST_Ni low before the next edge -> RD_VALID_o=0 and RD_DATA_o=0 immediately; after release all registers read 0x00.
- With REGFILE_ZERO_REG_EN defined, write 0x77 to addr 0 while reading addr 0 -> returns 0x00. Without the macro the same sequence returns 0x77 (bypass), then 0x77 from storage.
